// File: rtl/aes_pkg.sv
// Shared AES-128 types, constant tables and byte-level helper functions.
package aes_pkg;

    localparam int unsigned AES_W = 128;
    localparam int unsigned RND_W = $clog2(11);

    typedef logic [AES_W-1:0] t_aes_data;
    typedef logic [AES_W-1:0] t_aes_key;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round constant lookup; indices past the last round return zero
    function automatic logic [7:0] get_rcon(input logic [RND_W-1:0] idx);
        return (idx < RND_W'(10)) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: expands the next round key and transforms the state with it.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         last_i,
    output logic [127:0] state_o,
    output logic [127:0] key_o
);

    logic [31:0] w0, w1, w2, w3, t_w;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  sb [16];
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];

    // Key schedule step for the four words of the next round key
    assign w0  = key_i[127:96];
    assign w1  = key_i[95:64];
    assign w2  = key_i[63:32];
    assign w3  = key_i[31:0];
    assign t_w = sub_word(rot_word(w3)) ^ {rcon_i, 24'h000000};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign key_o = {n0, n1, n2, n3};

    // SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state_i[127-8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            state_o[127-8*i -: 8] = (last_i ? sr[i] : mc[i]) ^ key_o[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryption core with valid/ready on both sides and on-the-fly key expansion.
// UNROLL must divide 10 (1, 2, 5 or 10).
module aes128_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned UNROLL = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_key,
    input  logic [127:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [RND_W-1:0] UNROLL_R = RND_W'(UNROLL);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

    aes_state_e       state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    t_aes_data        st_q, st_d;
    t_aes_key         rk_q, rk_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic [RND_W-1:0] rnd_sum;

    t_aes_data st_chain [UNROLL+1];
    t_aes_key  rk_chain [UNROLL+1];

    assign st_chain[0] = st_q;
    assign rk_chain[0] = rk_q;

    // Chain of UNROLL rounds evaluated in one cycle, each feeding the next its key
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [RND_W-1:0] idx;
        assign idx = rnd_q + RND_W'(g);
        aes_round u_round (
            .state_i (st_chain[g]),
            .key_i   (rk_chain[g]),
            .rcon_i  (get_rcon(idx)),
            .last_i  (idx == RND_W'(9)),
            .state_o (st_chain[g+1]),
            .key_o   (rk_chain[g+1])
        );
    end

    // Ready while empty, or while the finished block leaves in this same cycle
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign rnd_sum  = rnd_q + UNROLL_R;

    // Next-state, datapath load and round advance
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        rk_d    = rk_q;
        tag_d   = tag_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    st_d    = in_data ^ in_key;
                    rk_d    = in_key;
                    tag_d   = in_tag;
                    rnd_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                st_d  = st_chain[UNROLL];
                rk_d  = rk_chain[UNROLL];
                rnd_d = rnd_sum;
                if (rnd_sum == LAST_RND) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    st_d    = in_data ^ in_key;
                    rk_d    = in_key;
                    tag_d   = in_tag;
                    rnd_d   = '0;
                    state_d = S_RUN;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            rk_q        <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = st_q;
    assign out_tag   = tag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Directed bench for aes128_cipher_iter: FIPS-197 vectors at UNROLL 1/2/5/10, handshake and reset cases.
module tb_aes128_cipher_iter;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_key;
    logic [127:0] in_data;
    logic [3:0]   in_tag;
    logic         out_ready;

    logic         rdy [4];
    logic         vld [4];
    logic         bsy [4];
    logic [127:0] odat [4];
    logic [3:0]   otag [4];

    int total = 0;
    int bad   = 0;
    int exp_lat [4] = '{11, 6, 3, 2};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        aes128_cipher_iter #(.UNROLL(U), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .in_key    (in_key),
            .in_data   (in_data),
            .in_tag    (in_tag),
            .out_valid (vld[g]),
            .out_ready (out_ready),
            .out_data  (odat[g]),
            .out_tag   (otag[g]),
            .busy      (bsy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Single block through the UNROLL=1 core; latency counts edges from the accept edge inclusive
    task automatic run_vec(input logic [127:0] k, input logic [127:0] d, input logic [3:0] t,
                           input logic [127:0] exp, input string name);
        int n;
        in_key   = k;
        in_data  = d;
        in_tag   = t;
        in_valid = 1'b1;
        check({name, "_in_ready"}, 128'(rdy[0]), 128'(1));
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!vld[0] && n < 40) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 128'(n), 128'(11));
        check({name, "_data"}, odat[0], exp);
        check({name, "_tag"}, 128'(otag[0]), 128'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int lat [4];
        int n;
        int got_cnt;
        int got_cyc [2];
        logic [127:0] got_dat [2];
        logic [3:0]   got_tag [2];
        logic         drop_valid;
        int           hold_err;

        rst = 1'b1; in_valid = 1'b0; in_key = '0; in_data = '0; in_tag = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 128'(rdy[0]), 128'(1));
        check("rst_out_valid", 128'(vld[0]), 128'(0));
        check("rst_busy", 128'(bsy[0]), 128'(0));
        check("rst_out_data", odat[0], 128'(0));
        check("rst_out_tag", 128'(otag[0]), 128'(0));
        rst = 1'b0;

        // Idle hold
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_hold", 128'({rdy[0], vld[0], bsy[0]}), 128'(3'b100));
        end

        // FIPS-197 C.1 at UNROLL=1
        run_vec(KEY1, PT1, 4'h3, CT1, "c1");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // FIPS-197 B on all unroll factors at once
        do_reset();
        for (int u = 0; u < 4; u++) lat[u] = 0;
        in_key = KEY2; in_data = PT2; in_tag = 4'h5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (n = 1; n <= 20; n++) begin
            for (int u = 0; u < 4; u++) begin
                if (vld[u] && lat[u] == 0) lat[u] = n;
            end
            if (n < 20) tick();
        end
        for (int u = 0; u < 4; u++) begin
            check($sformatf("fipsb_u%0d_latency", u), 128'(lat[u]), 128'(exp_lat[u]));
            check($sformatf("fipsb_u%0d_data", u), odat[u], CT2);
            check($sformatf("fipsb_u%0d_tag", u), 128'(otag[u]), 128'(5));
        end

        // Backpressure: result held, other input ignored
        in_key = KEY1; in_data = PT1; in_tag = 4'h9; in_valid = 1'b1;
        hold_err = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (odat[0] !== CT2 || otag[0] !== 4'h5 || rdy[0] !== 1'b0 || vld[0] !== 1'b1) hold_err++;
        end
        check("bp_hold", 128'(hold_err), 128'(0));
        check("bp_data", odat[0], CT2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 128'(rdy[0]), 128'(1));
        tick();
        out_ready = 1'b0;
        check("bp_drop_valid", 128'(vld[0]), 128'(0));
        check("bp_drop_busy", 128'(bsy[0]), 128'(0));

        // Back-to-back: second accept coincides with first result leaving
        out_ready = 1'b1;
        in_key = KEY1; in_data = PT1; in_tag = 4'h3; in_valid = 1'b1;
        tick();
        in_key = KEY2; in_data = PT2; in_tag = 4'h5;
        got_cnt = 0;
        drop_valid = 1'b0;
        for (n = 1; n < 60 && got_cnt < 2; n++) begin
            if (vld[0]) begin
                got_dat[got_cnt] = odat[0];
                got_tag[got_cnt] = otag[0];
                got_cyc[got_cnt] = n;
                if (got_cnt == 0) begin
                    check("b2b_ready_on_first", 128'(rdy[0]), 128'(1));
                    drop_valid = 1'b1;
                end
                got_cnt++;
            end
            if (got_cnt < 2) begin
                tick();
                if (drop_valid) in_valid = 1'b0;
            end
        end
        check("b2b_count", 128'(got_cnt), 128'(2));
        if (got_cnt == 2) begin
            check("b2b_data0", got_dat[0], CT1);
            check("b2b_tag0", 128'(got_tag[0]), 128'(3));
            check("b2b_data1", got_dat[1], CT2);
            check("b2b_tag1", 128'(got_tag[1]), 128'(5));
            check("b2b_spacing", 128'(got_cyc[1] - got_cyc[0]), 128'(11));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // Reset during round 4 discards the block
        in_key = KEY1; in_data = PT1; in_tag = 4'h3; in_valid = 1'b1;
        check("mid_rst_in_ready", 128'(rdy[0]), 128'(1));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_busy_before", 128'(bsy[0]), 128'(1));
        do_reset();
        check("mid_rst_after", 128'({rdy[0], bsy[0], vld[0]}), 128'(3'b100));
        hold_err = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (vld[0] !== 1'b0) hold_err++;
        end
        check("mid_rst_no_result", 128'(hold_err), 128'(0));
        run_vec(KEY2, PT2, 4'h6, CT2, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
